// File: rtl/psubsb_serial_if.sv
// Operand/result bundle for the lane-serial saturating packed subtractor.
// master = EX-stage requester, slave = psubsb_serial.
interface psubsb_serial_if #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 4
);
    localparam int DW = NUM_LANES * LANE_W;

    logic                 start;
    logic [DW-1:0]        A;
    logic [DW-1:0]        B;
    logic                 busy;
    logic                 done;
    logic [DW-1:0]        Diff;
    logic [NUM_LANES-1:0] lane_ov;
    logic                 Error;

    modport master (output start, A, B, input busy, done, Diff, lane_ov, Error);
    modport slave  (input start, A, B, output busy, done, Diff, lane_ov, Error);
endinterface

// File: rtl/psubsb_serial.sv
// Lane-serial saturating packed signed subtractor: Diff = A - B, one lane per clock.
// Optional sticky error flag (clr_err/err_sticky ports) under PSUBSB_STICKY_ERR_EN.
module psubsb_lane #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] d,
    output logic              ov
);
    logic [LANE_W:0] dx;

    always_comb begin
        dx = {a[LANE_W-1], a} - {b[LANE_W-1], b};
        ov = (a[LANE_W-1] != b[LANE_W-1]) && (dx[LANE_W-1] != a[LANE_W-1]);
        d  = dx[LANE_W-1:0];
        if (ov)
            d = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end
endmodule

module psubsb_serial #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef PSUBSB_STICKY_ERR_EN
    input  logic clr_err,
    output logic err_sticky,
`endif
    psubsb_serial_if.slave io
);
    localparam int DW = NUM_LANES * LANE_W;
    localparam int CW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [DW-1:0]        a_r, b_r, diff_r;
    logic [NUM_LANES-1:0] ov_r;
    logic                 err_r, busy_r, done_r;

    logic [LANE_W-1:0]    a_lane, b_lane, d_lane;
    logic                 ov_lane;
    logic [NUM_LANES-1:0] ov_next;

    always_comb begin
        a_lane  = a_r[cnt*LANE_W +: LANE_W];
        b_lane  = b_r[cnt*LANE_W +: LANE_W];
        ov_next = ov_r | (NUM_LANES'(ov_lane) << cnt);
    end

    psubsb_lane #(.LANE_W(LANE_W)) u_lane (
        .a  (a_lane),
        .b  (b_lane),
        .d  (d_lane),
        .ov (ov_lane)
    );

    // Accept is shared by IDLE and DONE so back-to-back ops lose no cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            ov_r   <= '0;
            err_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    diff_r[cnt*LANE_W +: LANE_W] <= d_lane;
                    ov_r  <= ov_next;
                    err_r <= |ov_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(NUM_LANES - 1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                    if (io.start) begin
                        a_r    <= io.A;
                        b_r    <= io.B;
                        diff_r <= '0;
                        ov_r   <= '0;
                        err_r  <= 1'b0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
            endcase
        end
    end

`ifdef PSUBSB_STICKY_ERR_EN
    // Set has priority over clr_err when an overflowing lane is written.
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_sticky <= 1'b0;
        else if (state == RUN && |ov_next)
            err_sticky <= 1'b1;
        else if (clr_err)
            err_sticky <= 1'b0;
    end
`endif

    assign io.busy    = busy_r;
    assign io.done    = done_r;
    assign io.Diff    = diff_r;
    assign io.lane_ov = ov_r;
    assign io.Error   = err_r;
endmodule
